// File: rtl/div_pkg.sv
// Shared constants and types for the iterative RV32M divider.
package div_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, i_div};
  // When w_ge holds the true difference fits in XLEN bits, so the modular result is exact.
  assign w_sub   = w_shift[XLEN-1:0] - i_div;
  assign o_rem   = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with pipeline stall output.
// Optional feature: define DIV_EARLY_OUT_EN to resolve divide-by-zero and signed overflow in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  input  logic            ex_advance,
  output logic            div_stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_t      r_state;
  div_state_t      w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_finish;
  logic            w_signed;
  logic            w_is_rem;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [XLEN-1:0] w_res_fin;
  logic            w_early;
  logic [XLEN-1:0] w_early_res;

  assign w_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_is_rem = (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign w_a_neg  = w_signed & op_a[XLEN-1];
  assign w_b_neg  = w_signed & op_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~op_a + 1'b1) : op_a;
  assign w_b_mag  = w_b_neg ? (~op_b + 1'b1) : op_b;

`ifdef DIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic w_b_zero;
  logic w_ovf;
  assign w_b_zero    = (op_b == '0);
  assign w_ovf       = w_signed && (op_a == INT_MIN) && (op_b == '1);
  assign w_early     = w_b_zero | w_ovf;
  assign w_early_res = w_is_rem ? (w_b_zero ? op_a : '0)
                                : (w_b_zero ? '1 : INT_MIN);
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  // Corner cases fall out naturally: /0 gives all-ones quotient and rem=|a|.
  assign w_q_fin   = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_r_fin   = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
  assign w_res_fin = r_is_rem ? w_r_fin : w_q_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    div_stall  = 1'b0;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          div_stall  = 1'b1;
          w_accept   = 1'b1;
          w_state_nx = w_early ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          w_state_nx = IDLE;
        end else begin
          div_stall = 1'b1;
          if (r_cnt == '0) begin
            w_finish   = 1'b1;
            w_state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (flush || ex_advance) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= CNT_W'(XLEN - 1);
      r_rem    <= '0;
      r_quo    <= w_a_mag;
      r_div    <= w_b_mag;
      r_neg_q  <= (w_a_neg ^ w_b_neg) && (op_b != '0);
      r_neg_r  <= w_a_neg;
      r_is_rem <= w_is_rem;
      if (w_early) begin
        r_result <= w_early_res;
      end
    end else if (r_state == BUSY) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_result <= w_res_fin;
      end
    end
  end

  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: timing, sign rules, corner results, hold, flush and reset.
`timescale 1ns/1ps
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        ex_advance;
  logic        div_stall;
  logic        done;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .ex_advance (ex_advance),
    .div_stall  (div_stall),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, count stall cycles until done, check result, optionally hold, then advance.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input bit corner, input int hold);
    int stalls;
    int cyc;
    int exp_lat;
    exp_lat = (corner && EARLY) ? 1 : DIV_ITERS + 1;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; ex_advance = 1'b0;
    stalls = 0;
    cyc = 0;
    #1;
    while (!done && cyc < 200) begin
      if (div_stall) stalls++;
      cyc++;
      @(negedge clk);
      op_a = ~a;
      op_b = b + 32'd3;
      #1;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " stall_in_done"}, {31'd0, div_stall}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk({tag, " hold_done"}, {31'd0, done}, 32'd1);
      chk({tag, " hold_stall"}, {31'd0, div_stall}, 32'd0);
      chk({tag, " hold_result"}, result, exp_res);
    end
    ex_advance = 1'b1;
    start = 1'b0;
    @(negedge clk);
    ex_advance = 1'b0;
    #1;
    chk({tag, " idle_after_advance"}, {31'd0, done}, 32'd0);
    $display("op %s f3=%b a=0x%08h b=0x%08h result=0x%08h stalls=%0d", tag, f3, a, b, result, stalls);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = F3_DIVU; op_a = '0; op_b = '0;
    flush = 1'b0; ex_advance = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset stall", {31'd0, div_stall}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    do_op("divu_100_7",   F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
    do_op("remu_100_7",   F3_REMU, 32'd100, 32'd7, 32'd2,  1'b0, 0);
    do_op("div_m7_2",     F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
    do_op("rem_m7_2",     F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    do_op("div_7_m2",     F3_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
    do_op("rem_7_m2",     F3_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
    do_op("divu_big_3",   F3_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1'b0, 0);
    do_op("remu_big_16",  F3_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 1'b0, 0);
    do_op("div_min_0",    F3_DIV,  32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("rem_min_0",    F3_REM,  32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1, 0);
    do_op("divu_5_0",     F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("remu_5_0",     F3_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 0);
    do_op("div_ovf",      F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    do_op("rem_ovf",      F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    do_op("divu_hold",    F3_DIVU, 32'd1000, 32'd9, 32'd111, 1'b0, 5);

    // Flush during BUSY, start still asserted in the flush cycle.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; ex_advance = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush stall", {31'd0, div_stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("after_flush done", {31'd0, done}, 32'd0);
    chk("after_flush stall", {31'd0, div_stall}, 32'd0);
    $display("flush during BUSY: done=%0b stall=%0b", done, div_stall);
    do_op("div_after_flush", F3_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 0);

    // Asynchronous reset pulse during BUSY.
    @(negedge clk);
    start = 1'b1; funct3 = F3_REMU; op_a = 32'd12345; op_b = 32'd100; ex_advance = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_mid done", {31'd0, done}, 32'd0);
    chk("rst_mid stall", {31'd0, div_stall}, 32'd0);
    chk("rst_mid result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release done", {31'd0, done}, 32'd0);
    $display("reset during BUSY: done=%0b stall=%0b result=0x%08h", done, div_stall, result);
    do_op("rem_after_rst", F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
